// File: rtl/id_ex_pkg.sv
// Shared definitions for the ID/EX pipeline stage: control-bundle bit layout and types.
package id_ex_pkg;

  localparam int unsigned CTRL_W = 10;

  localparam int unsigned REGDST    = 0;
  localparam int unsigned ALUSRC    = 1;
  localparam int unsigned MEMTOREG  = 2;
  localparam int unsigned REGWRITE  = 3;
  localparam int unsigned MEMREAD   = 4;
  localparam int unsigned MEMWRITE  = 5;
  localparam int unsigned BRANCH    = 6;
  localparam int unsigned ALUOP_LSB = 7;
  localparam int unsigned ALUOP_MSB = 9;

  typedef logic [CTRL_W-1:0] ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard compare between the load in EX and the instruction in ID.
module load_use_detect #(
  parameter int unsigned REG_ADDR_W  = 3,
  parameter int unsigned ZERO_REG_HW = 1
) (
  input  logic                  ex_valid,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  output logic                  hazard
);

  logic rt_match;
  logic zero_exempt;

  always_comb begin
    rt_match    = (ex_rt == id_rs) || (ex_rt == id_rt);
    // Hardwired r0 is never really written, so a load into it creates no dependence.
    zero_exempt = (ZERO_REG_HW != 0) && (ex_rt == '0);
    hazard      = ex_valid && ex_mem_read && id_valid && rt_match && !zero_exempt;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with valid bit, branch flush, load-use bubble/stall and
// a saturating bubble counter. State updates on the falling clock edge.
module id_ex_stage #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned REG_ADDR_W  = 3,
  parameter int unsigned OP_W        = 3,
  parameter int unsigned CTRL_W      = 10,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned ZERO_REG_HW = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hit,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic [DATA_W-1:0]     id_pc_next,
  input  logic [CTRL_W-1:0]     id_ctrl,
  input  logic [OP_W-1:0]       id_opcode,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic [DATA_W-1:0]     id_rd1,
  input  logic [DATA_W-1:0]     id_rd2,
  input  logic [DATA_W-1:0]     id_imm,
  output logic                  ex_valid,
  output logic [DATA_W-1:0]     ex_pc_next,
  output logic [CTRL_W-1:0]     ex_ctrl,
  output logic [OP_W-1:0]       ex_opcode,
  output logic [REG_ADDR_W-1:0] ex_rs,
  output logic [REG_ADDR_W-1:0] ex_rt,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic [DATA_W-1:0]     ex_rd1,
  output logic [DATA_W-1:0]     ex_rd2,
  output logic [DATA_W-1:0]     ex_imm,
  output logic                  hit_out,
  output logic                  stall_id,
  output logic [CNT_W-1:0]      bubble_cnt
);

  import id_ex_pkg::*;

  logic hazard;
  logic bubble;

  load_use_detect #(
    .REG_ADDR_W  (REG_ADDR_W),
    .ZERO_REG_HW (ZERO_REG_HW)
  ) u_load_use_detect (
    .ex_valid    (ex_valid),
    .ex_mem_read (ex_ctrl[MEMREAD]),
    .ex_rt       (ex_rt),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .hazard      (hazard)
  );

  always_comb begin
    bubble   = flush || hazard;
    // A flush already discards the ID instruction, so holding IF/ID would be pointless.
    stall_id = hazard && hit && !flush;
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      ex_valid   <= 1'b0;
      ex_pc_next <= '0;
      ex_ctrl    <= '0;
      ex_opcode  <= '0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_rd      <= '0;
      ex_rd1     <= '0;
      ex_rd2     <= '0;
      ex_imm     <= '0;
      hit_out    <= 1'b0;
      bubble_cnt <= '0;
    end else if (hit) begin
      ex_pc_next <= id_pc_next;
      ex_opcode  <= id_opcode;
      ex_rs      <= id_rs;
      ex_rt      <= id_rt;
      ex_rd      <= id_rd;
      ex_rd1     <= id_rd1;
      ex_rd2     <= id_rd2;
      ex_imm     <= id_imm;
      hit_out    <= 1'b1;
      if (bubble || !id_valid) begin
        ex_valid <= 1'b0;
        ex_ctrl  <= CTRL_W'(CTRL_NOP);
      end else begin
        ex_valid <= 1'b1;
        ex_ctrl  <= id_ctrl;
      end
      if (bubble && (bubble_cnt != '1)) begin
        bubble_cnt <= bubble_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: two instances (r0 exempt / not exempt) against a behavioural model.
module tb_id_ex_stage;

  logic        clk;
  logic        rst, hit, flush, id_valid;
  logic [15:0] id_pc_next, id_rd1, id_rd2, id_imm;
  logic [9:0]  id_ctrl;
  logic [2:0]  id_opcode, id_rs, id_rt, id_rd;

  logic        a_v, a_ho, a_stall;
  logic [15:0] a_pc, a_rd1, a_rd2, a_imm;
  logic [9:0]  a_ctrl;
  logic [2:0]  a_op, a_rs, a_rt, a_rd;
  logic [1:0]  a_cnt;

  logic        b_v, b_ho, b_stall;
  logic [15:0] b_pc, b_rd1, b_rd2, b_imm;
  logic [9:0]  b_ctrl;
  logic [2:0]  b_op, b_rs, b_rt, b_rd;
  logic [7:0]  b_cnt;

  int nchk = 0;
  int nerr = 0;
  bit started = 0;

  id_ex_stage #(.CNT_W(2), .ZERO_REG_HW(1)) dut_a (
    .clk(clk), .rst(rst), .hit(hit), .flush(flush), .id_valid(id_valid),
    .id_pc_next(id_pc_next), .id_ctrl(id_ctrl), .id_opcode(id_opcode),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_rd1(id_rd1), .id_rd2(id_rd2),
    .id_imm(id_imm), .ex_valid(a_v), .ex_pc_next(a_pc), .ex_ctrl(a_ctrl),
    .ex_opcode(a_op), .ex_rs(a_rs), .ex_rt(a_rt), .ex_rd(a_rd), .ex_rd1(a_rd1),
    .ex_rd2(a_rd2), .ex_imm(a_imm), .hit_out(a_ho), .stall_id(a_stall), .bubble_cnt(a_cnt)
  );

  id_ex_stage #(.CNT_W(8), .ZERO_REG_HW(0)) dut_b (
    .clk(clk), .rst(rst), .hit(hit), .flush(flush), .id_valid(id_valid),
    .id_pc_next(id_pc_next), .id_ctrl(id_ctrl), .id_opcode(id_opcode),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_rd1(id_rd1), .id_rd2(id_rd2),
    .id_imm(id_imm), .ex_valid(b_v), .ex_pc_next(b_pc), .ex_ctrl(b_ctrl),
    .ex_opcode(b_op), .ex_rs(b_rs), .ex_rt(b_rt), .ex_rd(b_rd), .ex_rd1(b_rd1),
    .ex_rd2(b_rd2), .ex_imm(b_imm), .hit_out(b_ho), .stall_id(b_stall), .bubble_cnt(b_cnt)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  // Model of what EX must hold after each falling edge.
  typedef struct packed {
    bit        v;
    bit [15:0] pc, rd1, rd2, imm;
    bit [9:0]  ctrl;
    bit [2:0]  op, rs, rt, rd;
    bit        ho;
    int        cnt;
  } m_t;

  m_t ma = '0;
  m_t mb = '0;

  function automatic bit m_hz(m_t s, bit zhw);
    bit dep;
    dep = (s.rt == id_rs) || (s.rt == id_rt);
    return s.v && s.ctrl[4] && id_valid && dep && !(zhw && s.rt == 3'd0);
  endfunction

  function automatic m_t m_next(m_t s, bit zhw, int maxc);
    m_t n;
    bit bub;
    n = s;
    if (rst) begin
      n = '0;
    end else if (hit) begin
      bub   = flush || m_hz(s, zhw);
      n.pc  = id_pc_next;
      n.rd1 = id_rd1;
      n.rd2 = id_rd2;
      n.imm = id_imm;
      n.op  = id_opcode;
      n.rs  = id_rs;
      n.rt  = id_rt;
      n.rd  = id_rd;
      n.v   = !bub && id_valid;
      n.ctrl = n.v ? id_ctrl : 10'd0;
      n.ho  = 1'b1;
      if (bub && s.cnt < maxc) n.cnt = s.cnt + 1;
    end
    return n;
  endfunction

  task automatic cmp(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    ma <= m_next(ma, 1'b1, 3);
    mb <= m_next(mb, 1'b0, 255);
    started <= 1'b1;
  end

  always @(posedge clk) begin
    if (started) begin
      cmp("A.ex_valid", int'(a_v), int'(ma.v));
      cmp("A.ex_pc_next", int'(a_pc), int'(ma.pc));
      cmp("A.ex_ctrl", int'(a_ctrl), int'(ma.ctrl));
      cmp("A.ex_opcode", int'(a_op), int'(ma.op));
      cmp("A.ex_rs", int'(a_rs), int'(ma.rs));
      cmp("A.ex_rt", int'(a_rt), int'(ma.rt));
      cmp("A.ex_rd", int'(a_rd), int'(ma.rd));
      cmp("A.ex_rd1", int'(a_rd1), int'(ma.rd1));
      cmp("A.ex_rd2", int'(a_rd2), int'(ma.rd2));
      cmp("A.ex_imm", int'(a_imm), int'(ma.imm));
      cmp("A.hit_out", int'(a_ho), int'(ma.ho));
      cmp("A.bubble_cnt", int'(a_cnt), ma.cnt);
      cmp("A.stall_id", int'(a_stall), int'(m_hz(ma, 1'b1) && hit && !flush));
      cmp("B.ex_valid", int'(b_v), int'(mb.v));
      cmp("B.ex_pc_next", int'(b_pc), int'(mb.pc));
      cmp("B.ex_ctrl", int'(b_ctrl), int'(mb.ctrl));
      cmp("B.ex_opcode", int'(b_op), int'(mb.op));
      cmp("B.ex_rs", int'(b_rs), int'(mb.rs));
      cmp("B.ex_rt", int'(b_rt), int'(mb.rt));
      cmp("B.ex_rd", int'(b_rd), int'(mb.rd));
      cmp("B.ex_rd1", int'(b_rd1), int'(mb.rd1));
      cmp("B.ex_rd2", int'(b_rd2), int'(mb.rd2));
      cmp("B.ex_imm", int'(b_imm), int'(mb.imm));
      cmp("B.hit_out", int'(b_ho), int'(mb.ho));
      cmp("B.bubble_cnt", int'(b_cnt), mb.cnt);
      cmp("B.stall_id", int'(b_stall), int'(m_hz(mb, 1'b0) && hit && !flush));
    end
  end

  task automatic step();
    @(negedge clk);
    @(posedge clk);
  endtask

  task automatic set_id(input bit v, input bit [9:0] c, input bit [2:0] rs, input bit [2:0] rt,
                        input bit [15:0] d1);
    id_valid   = v;
    id_ctrl    = c;
    id_rs      = rs;
    id_rt      = rt;
    id_rd1     = d1;
    id_rd      = 3'($urandom);
    id_opcode  = 3'($urandom);
    id_pc_next = 16'($urandom);
    id_rd2     = 16'($urandom);
    id_imm     = 16'($urandom);
  endtask

  int sat_exp [5] = '{1, 2, 3, 3, 3};

  initial begin
    rst = 1'b1;
    hit = 1'($urandom);
    flush = 1'($urandom);
    set_id(1'($urandom), 10'($urandom), 3'($urandom), 3'($urandom), 16'($urandom));
    step();
    set_id(1'($urandom), 10'($urandom), 3'($urandom), 3'($urandom), 16'($urandom));
    step();
    cmp("rst ex_valid", int'(a_v), 0);
    cmp("rst ex_ctrl", int'(a_ctrl), 0);
    cmp("rst ex_rd1", int'(b_rd1), 0);
    cmp("rst hit_out", int'(a_ho), 0);
    cmp("rst bubble_cnt", int'(a_cnt), 0);

    #1 rst = 1'b0; hit = 1'b1; flush = 1'b0;
    set_id(1'b1, 10'h008, 3'd1, 3'd2, 16'h1234);
    step();
    cmp("release ex_rd1", int'(a_rd1), 'h1234);
    cmp("release ex_valid", int'(a_v), 1);
    cmp("release hit_out", int'(a_ho), 1);

    for (int i = 0; i < 3; i++) begin
      #1 hit = 1'b0;
      set_id(1'b1, 10'($urandom), 3'($urandom), 3'($urandom), 16'($urandom));
      step();
      cmp("freeze ex_rd1", int'(a_rd1), 'h1234);
      cmp("freeze stall_id", int'(a_stall), 0);
      cmp("freeze bubble_cnt", int'(a_cnt), 0);
    end
    #1 hit = 1'b1;
    set_id(1'b1, 10'h00B, 3'd1, 3'd2, 16'hBEEF);
    step();
    cmp("unfreeze ex_rd1", int'(a_rd1), 'hBEEF);
    cmp("unfreeze ex_ctrl", int'(a_ctrl), 'h00B);

    // lw into EX with rt=3, then a dependent instruction in ID
    #1 set_id(1'b1, 10'h018, 3'd1, 3'd3, 16'h0);
    step();
    #1 set_id(1'b1, 10'h008, 3'd3, 3'd5, 16'h1111);
    #1 cmp("loaduse stall_id", int'(a_stall), 1);
    step();
    cmp("loaduse bubble valid", int'(a_v), 0);
    cmp("loaduse bubble ctrl", int'(a_ctrl), 0);
    cmp("loaduse bubble_cnt", int'(a_cnt), 1);
    step();
    cmp("loaduse reload valid", int'(a_v), 1);
    cmp("loaduse reload ctrl", int'(a_ctrl), 'h008);
    cmp("loaduse reload rd1", int'(a_rd1), 'h1111);

    // lw into r0: exempt on A, hazard on B
    #1 set_id(1'b1, 10'h018, 3'd1, 3'd0, 16'h0);
    step();
    #1 set_id(1'b1, 10'h008, 3'd0, 3'd2, 16'h2222);
    #1 cmp("zero A stall_id", int'(a_stall), 0);
    cmp("zero B stall_id", int'(b_stall), 1);
    step();
    cmp("zero A valid", int'(a_v), 1);
    cmp("zero B valid", int'(b_v), 0);
    cmp("zero A bubble_cnt", int'(a_cnt), 1);
    cmp("zero B bubble_cnt", int'(b_cnt), 2);
    step();
    cmp("zero B reload rd1", int'(b_rd1), 'h2222);

    // flush coinciding with a load-use hazard
    #1 set_id(1'b1, 10'h018, 3'd1, 3'd3, 16'h0);
    step();
    #1 set_id(1'b1, 10'h008, 3'd3, 3'd4, 16'h3333);
    flush = 1'b1;
    #1 cmp("flushhz A stall_id", int'(a_stall), 0);
    cmp("flushhz B stall_id", int'(b_stall), 0);
    step();
    cmp("flushhz valid", int'(a_v), 0);
    cmp("flushhz A bubble_cnt", int'(a_cnt), 2);
    cmp("flushhz B bubble_cnt", int'(b_cnt), 3);
    #1 flush = 1'b0;
    step();
    cmp("after flush valid", int'(a_v), 1);
    cmp("after flush bubble_cnt", int'(a_cnt), 2);

    // invalid ID instruction: no control, no bubble counted
    #1 set_id(1'b0, 10'h3FF, 3'd6, 3'd7, 16'h4444);
    step();
    cmp("invalid ex_valid", int'(a_v), 0);
    cmp("invalid ex_ctrl", int'(a_ctrl), 0);
    cmp("invalid bubble_cnt", int'(a_cnt), 2);

    #1 rst = 1'b1;
    step();
    cmp("rst2 bubble_cnt", int'(a_cnt), 0);
    #1 rst = 1'b0; flush = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      cmp("saturate bubble_cnt", int'(a_cnt), sat_exp[i]);
      #1 set_id(1'b1, 10'($urandom), 3'($urandom), 3'($urandom), 16'($urandom));
    end
    cmp("saturate B bubble_cnt", int'(b_cnt), 5);
    #1 rst = 1'b1; flush = 1'b0;
    step();
    cmp("rst3 A bubble_cnt", int'(a_cnt), 0);
    cmp("rst3 B bubble_cnt", int'(b_cnt), 0);
    cmp("rst3 hit_out", int'(a_ho), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
